// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot-time controller for the core's byte-wide instruction RAM. While a load
// session runs it holds the core in reset. It accepts 32-bit program words on a
// valid/ready stream and writes each word to the RAM write port as four bytes,
// most significant byte first. After the final word it waits a fixed number of
// cycles and then releases the core.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   When defined, a 'checksum' output is added. It holds the running sum
//   (mod 2**32) of every word actually written during the current session.
//
// Parameters
//   ADDR_WIDTH  byte-address width of the instruction RAM (capacity 2**(ADDR_WIDTH-2) words)
//   RESET_HOLD  cycles core_reset stays high after the last byte write (>=1)
//
// Ports
//   clock       system clock; all state changes on the rising edge
//   reset       synchronous, active-high
//   start       one-cycle pulse that begins a load session (from IDLE or RUN)
//   in_valid    program word valid
//   in_ready    loader can accept a word (high only while loading)
//   in_data     program word
//   in_last     marks in_data as the final word of the session
//   ram_we      instruction RAM byte write enable
//   ram_addr    instruction RAM byte address
//   ram_wdata   instruction RAM write byte
//   core_reset  reset to the core; low only when the program is running
//   mem_en      core memory enable; high only when the program is running
//   busy        session in progress (loading, writing or holding)
//   word_count  number of words written in this session
//   overflow    sticky flag: a word arrived while the RAM was full
//   checksum    (BOOT_CHECKSUM_EN only) running sum of written words
// -----------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int RESET_HOLD = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_data,
   input  logic                  in_last,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]            ram_wdata,
   output logic                  core_reset,
   output logic                  mem_en,
   output logic                  busy,
   output logic [ADDR_WIDTH-2:0] word_count,
   output logic                  overflow
`ifdef BOOT_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);

   localparam int WC_W = ADDR_WIDTH - 1;
   localparam logic [WC_W-1:0] MAX_WORDS = WC_W'(2 ** (ADDR_WIDTH - 2));
   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      HOLD,
      RUN
   } state_t;

   state_t                state_q,      state_d;
   logic [1:0]            byte_idx_q,   byte_idx_d;
   logic [HOLD_W-1:0]     hold_cnt_q,   hold_cnt_d;
   logic [31:0]           word_q,       word_d;
   logic                  last_q,       last_d;
   logic                  ram_we_q,     ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
   logic [7:0]            ram_wdata_q,  ram_wdata_d;
   logic                  in_ready_q,   in_ready_d;
   logic                  core_reset_q, core_reset_d;
   logic                  mem_en_q,     mem_en_d;
   logic                  busy_q,       busy_d;
   logic [WC_W-1:0]       word_count_q, word_count_d;
   logic                  overflow_q,   overflow_d;
`ifdef BOOT_CHECKSUM_EN
   logic [31:0]           checksum_q,   checksum_d;
`endif

   logic [1:0]            byte_next;

   // Byte b of a word, most significant byte first.
   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] b);
      case (b)
         2'd0:    return w[31:24];
         2'd1:    return w[23:16];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   // Next-state and next-output logic. All outputs are registered, so every
   // output value is decided here one cycle ahead of when it appears.
   always_comb begin
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      hold_cnt_d   = hold_cnt_q;
      word_d       = word_q;
      last_d       = last_q;
      ram_we_d     = ram_we_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      in_ready_d   = in_ready_q;
      core_reset_d = core_reset_q;
      mem_en_d     = mem_en_q;
      busy_d       = busy_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;
`ifdef BOOT_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif
      byte_next    = byte_idx_q + 2'd1;

      case (state_q)
         IDLE, RUN: begin
            // A start pulse (re)opens a session; the core goes back into reset.
            if (start) begin
               state_d      = LOAD;
               in_ready_d   = 1'b1;
               busy_d       = 1'b1;
               core_reset_d = 1'b1;
               mem_en_d     = 1'b0;
               word_count_d = '0;
               overflow_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
               checksum_d   = '0;
`endif
            end
         end

         LOAD: begin
            if (in_valid && in_ready_q) begin
               word_d = in_data;
               last_d = in_last;
               if (word_count_q < MAX_WORDS) begin
                  // The first byte goes out on the very next cycle.
                  state_d     = WRITE;
                  byte_idx_d  = 2'd0;
                  in_ready_d  = 1'b0;
                  ram_we_d    = 1'b1;
                  ram_addr_d  = {word_count_q[WC_W-2:0], 2'd0};
                  ram_wdata_d = in_data[31:24];
               end else begin
                  // RAM is full: drop the word, but a final word still ends the session.
                  overflow_d = 1'b1;
                  if (in_last) begin
                     state_d    = HOLD;
                     hold_cnt_d = '0;
                     in_ready_d = 1'b0;
                  end
               end
            end
         end

         WRITE: begin
            if (byte_idx_q == 2'd3) begin
               ram_we_d     = 1'b0;
               word_count_d = word_count_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
               checksum_d   = checksum_q + word_q;
`endif
               if (last_q) begin
                  state_d    = HOLD;
                  hold_cnt_d = '0;
               end else begin
                  state_d    = LOAD;
                  in_ready_d = 1'b1;
               end
            end else begin
               byte_idx_d  = byte_next;
               ram_addr_d  = {word_count_q[WC_W-2:0], byte_next};
               ram_wdata_d = pick_byte(word_q, byte_next);
            end
         end

         HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d      = RUN;
               core_reset_d = 1'b0;
               mem_en_d     = 1'b1;
               busy_d       = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset aborts any session at once; bytes
   // already written stay in the RAM.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         byte_idx_q   <= '0;
         hold_cnt_q   <= '0;
         word_q       <= '0;
         last_q       <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         in_ready_q   <= 1'b0;
         core_reset_q <= 1'b1;
         mem_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         checksum_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         hold_cnt_q   <= hold_cnt_d;
         word_q       <= word_d;
         last_q       <= last_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         in_ready_q   <= in_ready_d;
         core_reset_q <= core_reset_d;
         mem_en_q     <= mem_en_d;
         busy_q       <= busy_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
`ifdef BOOT_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign core_reset = core_reset_q;
   assign mem_en     = mem_en_q;
   assign busy       = busy_q;
   assign word_count = word_count_q;
   assign overflow   = overflow_q;
`ifdef BOOT_CHECKSUM_EN
   assign checksum   = checksum_q;
`endif

endmodule
